dm_store_unit: RTL and testbench

- Data memory for the M stage, directly upstream of the load-extension stage.
- Performs byte, half and word stores with lane merging, flags misaligned accesses, and counts completed stores.
- Returns the full aligned word combinationally as DMout1; the load-extension stage selects and extends lanes from it.

---
 rtl/dm_store_unit.sv | 101 ++++++++++
 tb/tb_dm_store_unit.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/dm_store_unit.sv
// M-stage data memory: byte/half/word stores with lane merge, misalignment flags and a store counter.
// Define DM_DISPLAY_EN to print each committed store during simulation.
module dm_store_unit #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      Instr_M,
    input  logic [31:0]      ALUout,
    input  logic [31:0]      WD,
    input  logic [31:0]      PC_M,
    output logic [31:0]      DMout1,
    output logic             ld_err,
    output logic             st_err,
    output logic [CNT_W-1:0] wr_cnt
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]       mem [DEPTH];
    logic [5:0]        opcode;
    logic [ADDR_W-1:0] word_idx;
    logic [1:0]        offset;
    logic              is_store;
    logic              st_misalign;
    logic              st_commit;
    logic [31:0]       merged;

    function automatic logic [31:0] merge_word(input logic [31:0] old_w, input logic [31:0] wd,
                                               input logic [5:0] op, input logic [1:0] off);
        logic [31:0] w;
        w = old_w;
        case (op)
            OP_SW: w = wd;
            OP_SH: begin
                if (off[1]) w[31:16] = wd[15:0];
                else        w[15:0]  = wd[15:0];
            end
            OP_SB: begin
                case (off)
                    2'd0:    w[7:0]   = wd[7:0];
                    2'd1:    w[15:8]  = wd[7:0];
                    2'd2:    w[23:16] = wd[7:0];
                    default: w[31:24] = wd[7:0];
                endcase
            end
            default: ;
        endcase
        return w;
    endfunction

    assign opcode   = Instr_M[31:26];
    assign word_idx = ALUout[ADDR_W+1:2];
    assign offset   = ALUout[1:0];

    // Read port ignores the pending store: the new word appears only after the edge.
    assign DMout1 = mem[word_idx];

    assign is_store    = (opcode == OP_SB) || (opcode == OP_SH) || (opcode == OP_SW);
    assign st_misalign = ((opcode == OP_SH) && offset[0]) ||
                         ((opcode == OP_SW) && (offset != 2'b00));
    assign st_commit   = is_store && !st_misalign;
    assign merged      = merge_word(DMout1, WD, opcode, offset);

    assign ld_err = (((opcode == OP_LH) || (opcode == OP_LHU)) && offset[0]) ||
                    ((opcode == OP_LW) && (offset != 2'b00));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            st_err <= 1'b0;
            wr_cnt <= '0;
        end else begin
            if (st_commit) begin
                mem[word_idx] <= merged;
                wr_cnt        <= wr_cnt + CNT_ONE;
            end
            st_err <= st_misalign;
        end
    end

`ifdef DM_DISPLAY_EN
    always @(posedge clk) begin
        if (rst_n && st_commit)
            $display("%0t@%h: *%h <= %h", $time, PC_M, {ALUout[31:2], 2'b00}, merged);
    end
`endif

    // Bits that feed nothing in the default build.
    logic unused_bits;
    assign unused_bits = ^{PC_M, Instr_M[25:0], ALUout[31:ADDR_W+2]};

endmodule

// File: tb/tb_dm_store_unit.sv
// Randomized + directed bench for dm_store_unit against a byte-mask memory model.
module tb_dm_store_unit;

    localparam int AW  = 10;
    localparam int CW  = 4;
    localparam int DEP = 1 << AW;

    localparam logic [5:0] SB = 6'b101000, SH = 6'b101001, SW = 6'b101011;
    localparam logic [5:0] LB = 6'b100000, LBU = 6'b100100, LH = 6'b100001;
    localparam logic [5:0] LHU = 6'b100101, LW = 6'b100011, NOP = 6'b000000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   Instr_M, ALUout, WD, PC_M;
    logic [31:0]   DMout1;
    logic          ld_err, st_err;
    logic [CW-1:0] wr_cnt;

    logic [31:0] mem_m [DEP];
    int          cnt_m;
    logic        st_err_m;
    int          n_chk = 0;
    int          n_fail = 0;

    dm_store_unit #(.ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .Instr_M(Instr_M), .ALUout(ALUout), .WD(WD),
        .PC_M(PC_M), .DMout1(DMout1), .ld_err(ld_err), .st_err(st_err), .wr_cnt(wr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEP; i++) mem_m[i] = '0;
        cnt_m = 0;
        st_err_m = 1'b0;
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    function automatic logic exp_ld_err(input logic [5:0] op, input logic [31:0] a);
        if (op == LH || op == LHU) return a[0];
        if (op == LW) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    // Model of one clock edge: byte enables plus replicated data.
    task automatic model_edge(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        logic [3:0]  be;
        logic [31:0] data, mask;
        logic        bad;
        be = 4'b0000; data = '0; bad = 1'b0;
        if (op == SW) begin
            if (a[1:0] == 2'b00) begin be = 4'b1111; data = wd; end else bad = 1'b1;
        end else if (op == SH) begin
            if (!a[0]) begin be = a[1] ? 4'b1100 : 4'b0011; data = {2{wd[15:0]}}; end else bad = 1'b1;
        end else if (op == SB) begin
            be = 4'b0001 << a[1:0];
            data = {4{wd[7:0]}};
        end
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        if (be != 4'b0000) begin
            mem_m[widx(a)] = (mem_m[widx(a)] & ~mask) | (data & mask);
            cnt_m = (cnt_m + 1) % (1 << CW);
        end
        st_err_m = bad;
    endtask

    task automatic step(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd);
        Instr_M = {op, 26'($urandom)};
        ALUout = a;
        WD = wd;
        PC_M = $urandom;
        #1;
        check("dmout_pre", DMout1, mem_m[widx(a)]);
        check("ld_err", {31'b0, ld_err}, {31'b0, exp_ld_err(op, a)});
        @(posedge clk);
        model_edge(op, a, wd);
        #1;
        check("dmout_post", DMout1, mem_m[widx(a)]);
        check("wr_cnt", 32'(wr_cnt), 32'(cnt_m));
        check("st_err", {31'b0, st_err}, {31'b0, st_err_m});
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Instr_M = '0;
        ALUout = a;
        #1;
        check(tag, DMout1, exp);
        check({tag, "_model"}, DMout1, mem_m[widx(a)]);
    endtask

    initial begin
        logic [5:0] ops [10];
        ops = '{SB, SH, SW, LB, LBU, LH, LHU, LW, NOP, 6'h3f};
        rst_n = 1'b0;
        Instr_M = '0; ALUout = '0; WD = '0; PC_M = '0;
        model_reset();
        #12;
        check("rst_dmout", DMout1, 32'h0);
        check("rst_wr_cnt", 32'(wr_cnt), 32'h0);
        check("rst_st_err", {31'b0, st_err}, 32'h0);
        rst_n = 1'b1;

        step(SW, 32'h8, 32'h12345678);
        check("sw_word", DMout1, 32'h12345678);
        check("sw_cnt", 32'(wr_cnt), 32'd1);
        step(SB, 32'h9, 32'hFFFFFFAB);
        peek("sb_word", 32'h8, 32'h1234AB78);
        step(SH, 32'hA, 32'h0000CDEF);
        peek("sh_word", 32'h8, 32'hCDEFAB78);
        check("sh_cnt", 32'(wr_cnt), 32'd3);

        step(SW, 32'h6, 32'hDEADBEEF);
        check("mis_st_err", {31'b0, st_err}, 32'h1);
        check("mis_cnt", 32'(wr_cnt), 32'd3);
        peek("mis_word", 32'h4, 32'h0);
        step(LH, 32'h3, 32'h0);
        check("st_err_clear", {31'b0, st_err}, 32'h0);
        step(LW, 32'h8, 32'h0);

        step(SW, 32'h10, 32'h55AA55AA);
        peek("alias", 32'h10 + (32'h1 << (AW + 2)), 32'h55AA55AA);
        step(SH, 32'h11, 32'h1111);

        // Asynchronous reset between edges, with st_err high and memory populated.
        ALUout = 32'h10;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("arst_dmout", DMout1, 32'h0);
        check("arst_cnt", 32'(wr_cnt), 32'h0);
        check("arst_st_err", {31'b0, st_err}, 32'h0);
        Instr_M = {SW, 26'h0};
        ALUout = 32'h20;
        WD = 32'hCAFEF00D;
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        peek("rst_sw_lost", 32'h20, 32'h0);
        check("rst_sw_cnt", 32'(wr_cnt), 32'h0);

        for (int i = 0; i < 15; i++) step(SB, 32'(i * 4 + 1), $urandom);
        check("cnt_ones", 32'(wr_cnt), 32'hF);
        step(SW, 32'h40, 32'hA5A5A5A5);
        check("cnt_wrap", 32'(wr_cnt), 32'h0);

        for (int i = 0; i < 300; i++)
            step(ops[$urandom_range(0, 9)], $urandom & 32'hFFFF_F03F, $urandom);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
